clk_en_gen: RTL and testbench
=============================

// Module: clk_en_gen
// PURPOSE
//   Single-clock, N-channel programmable clock-enable generator with PLL-lock-qualified, staggered reset release.
//   Sits directly behind the PLL: consumes its lock flag, releases per-domain resets in order (channel 0 first),
//   and produces divided ce pulses so slow logic (UART, timers, peripherals) runs on the core clock without extra PLL outputs.
//   Divide ratios are runtime-writable from a simple write port (e.g. MMIO bridge).
// PARAMETERS
//   N_CH        4   number of enable/reset channels (1..16)
//   CNT_W       8   width of divide ratio and per-channel counter
//   LOCK_FILT   16  consecutive synchronised lock-high cycles required before release (>=1)
//   RST_STAGGER 8   cycles between successive channel reset releases (>=1)
//   DIV_INIT    1   divide ratio loaded into all channels on rst (0 treated as 1)
//   localparam SEL_W = (N_CH>1) ? $clog2(N_CH) : 1
// PORTS
//   clk      in   1      core clock, PLL output; all logic rising-edge
//   rst      in   1      synchronous, active-high reset
//   lock     in   1      PLL lock, asynchronous to clk
//   div_wr   in   1      write strobe for divide ratio, one cycle
//   div_sel  in   SEL_W  channel index for div_wr
//   div_val  in   CNT_W  new divide ratio
//   ce       out  N_CH   per-channel clock-enable pulses
//   rst_out  out  N_CH   per-channel synchronous active-high reset
//   ready    out  1      all channels released, lock stable
//   lost     out  1      sticky: lock dropped after release began; cleared only by rst
// BEHAVIOUR
//   Reset (rst=1 at an edge): state=WAIT_LOCK; sync flops=0; filter/stage/channel counters=0;
//     shadow[i]=act[i]=max(DIV_INIT,1); outputs: ce=0, rst_out=all 1, ready=0, lost=0. rst dominates every other input.
//   lock -> 2-flop synchroniser -> lock_s. All timing below is in rising edges, e1 = first edge sampling lock=1.
//   FSM:
//     WAIT_LOCK: fcnt++ on each edge with lock_s=1, fcnt<=0 on lock_s=0; fcnt reaching LOCK_FILT -> RELEASE, scnt=0.
//     RELEASE: scnt++ each edge; rst_out[i] clears at edge where scnt==i*RST_STAGGER;
//       when rst_out[N_CH-1] clears, same edge -> RUN, ready=1.
//     RUN: steady state.
//     Any state, lock_s=0 at edge: -> WAIT_LOCK, fcnt=0, rst_out=all 1, ready=0, channel counters=0;
//       lost<=1 if state was RELEASE or RUN. Lock glitch shorter than one clk may be missed; not required to catch.
//   Defaults: rst_out[i] falls at edge e(19+8i) (e19,e27,e35,e43); ready rises at e43. Lock fall at input -> outputs
//     reset after 3rd edge.
//   Channel i (counter cnt[i], CNT_W bits):
//     rst_out[i]=1: cnt=0, ce[i]=0, act[i]<=shadow[i] every cycle.
//     rst_out[i]=0: ce[i] = (cnt[i]==act[i]-1), decoded from registers only;
//       on ce[i]: cnt<=0, act[i]<=shadow[i]; else cnt++.
//     ce[i] first high in the act-th cycle after release, then every act cycles; act=1 -> ce[i] high every cycle.
//   Divide writes: div_wr=1 with div_sel<N_CH -> shadow[div_sel]<=(div_val==0 ? 1 : div_val) at that edge.
//     div_sel>=N_CH ignored. Accepted in every state. New ratio used from the wrap after the write (no truncated period);
//     a write on the same edge as a wrap takes effect at the following wrap. Last write before a wrap wins.
//   Ratio max 2^CNT_W-1; counter never wraps past act-1.
//   No combinational path from any input to any output.
// TESTING (defaults unless stated)
//   1. rst 3 cycles, lock=1 from e1 -> rst_out falls at e19/e27/e35/e43, ready at e43, ce=0 before release, lost=0.
//   2. lock pulses high 10 cycles then low, then high steady -> no release during pulse; release e19 counted from the second rise.
//   3. After ready, write ch2=5, ch3=0 -> ce[2] every 5 cycles from next wrap with no short period; ce[3] every cycle (0->1).
//   4. ch1 at 200, write 3 mid-period -> current 200-cycle period completes, then period 3; write div_sel=4 (N_CH=4) -> no change.
//   5. lock drops in RUN -> 3 edges later rst_out=F, ready=0, ce=0, lost=1; lock restored -> full staggered release, lost stays 1.
//   6. rst asserted in RELEASE with lock=1 -> next edge all reset values, lost=0; release restarts with e19 timing.

Source files
------------

// File: rtl/clk_en_gen_if.sv
// Purpose: groups the lock input, divide-ratio write port and per-channel outputs of clk_en_gen.
// Latency: none, this is wiring only.
// Backpressure: none; div_wr is a single-cycle strobe that is always accepted.
interface clk_en_gen_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
);
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic             lock;
    logic             div_wr;
    logic [SEL_W-1:0] div_sel;
    logic [CNT_W-1:0] div_val;
    logic [N_CH-1:0]  ce;
    logic [N_CH-1:0]  rst_out;
    logic             ready;
    logic             lost;

    modport master (
        output lock, div_wr, div_sel, div_val,
        input  ce, rst_out, ready, lost
    );

    modport slave (
        input  lock, div_wr, div_sel, div_val,
        output ce, rst_out, ready, lost
    );
endinterface

// File: rtl/clk_en_gen.sv
// Purpose: filters PLL lock, releases per-channel resets in order (channel 0 first), then divides clk into ce pulses.
// Latency: lock to ch0 release takes 2 sync + LOCK_FILT filter + 1 edges; a lock drop reaches the outputs after the 3rd edge.
// Backpressure: none; ratio writes land in a shadow register and take effect at the next wrap of that channel.
module clk_en_gen #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 8,
    parameter int LOCK_FILT   = 16,
    parameter int RST_STAGGER = 8,
    parameter int DIV_INIT    = 1
) (
    input  logic         clk,
    input  logic         rst,
    clk_en_gen_if.slave  bus
);
    // Final stagger count: the edge where the last channel leaves reset.
    localparam int SCNT_MAX = (N_CH - 1) * RST_STAGGER;
    // One spare code so scnt can sit at SCNT_MAX+1 once everything is released.
    localparam int SCNT_W   = $clog2(SCNT_MAX + 2);
    localparam int FCNT_W   = $clog2(LOCK_FILT + 1);
    localparam logic [CNT_W-1:0] DIV_RST = (DIV_INIT == 0) ? CNT_W'(1) : CNT_W'(DIV_INIT);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        RELEASE   = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                lock_m;
    logic                lock_s;
    logic [FCNT_W-1:0]   fcnt;
    logic [SCNT_W-1:0]   scnt;
    logic                lost;
    logic [N_CH-1:0]     rst_out_c;
    logic                ready_c;
    logic [N_CH-1:0]     ce_c;
    logic [CNT_W-1:0]    cnt    [N_CH];
    logic [CNT_W-1:0]    act    [N_CH];
    logic [CNT_W-1:0]    shadow [N_CH];

    // Two-flop synchroniser for the asynchronous PLL lock flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= bus.lock;
            lock_s <= lock_m;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_LOCK;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: losing lock wins from any state.
    always_comb begin
        state_nxt = state;
        if (!lock_s) begin
            state_nxt = WAIT_LOCK;
        end else begin
            case (state)
                WAIT_LOCK: if (fcnt == FCNT_W'(LOCK_FILT - 1)) state_nxt = RELEASE;
                RELEASE:   if (scnt == SCNT_W'(SCNT_MAX))      state_nxt = RUN;
                RUN:       state_nxt = RUN;
                default:   state_nxt = WAIT_LOCK;
            endcase
        end
    end

    // Lock filter and stagger counters; both restart whenever lock is seen low.
    always_ff @(posedge clk) begin
        if (rst || !lock_s) begin
            fcnt <= '0;
            scnt <= '0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    fcnt <= (state_nxt == RELEASE) ? '0 : fcnt + FCNT_W'(1);
                    scnt <= '0;
                end
                RELEASE: scnt <= scnt + SCNT_W'(1);
                default: ;
            endcase
        end
    end

    // FSM outputs: channel i is out of reset once the stagger count has passed i*RST_STAGGER.
    always_comb begin
        rst_out_c = '1;
        ready_c   = 1'b0;
        case (state)
            RUN: begin
                rst_out_c = '0;
                ready_c   = 1'b1;
            end
            RELEASE: begin
                for (int i = 0; i < N_CH; i++) begin
                    if (scnt > SCNT_W'(i * RST_STAGGER)) rst_out_c[i] = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Sticky flag: lock lost after release had already started.
    always_ff @(posedge clk) begin
        if (rst) begin
            lost <= 1'b0;
        end else if (!lock_s && (state != WAIT_LOCK)) begin
            lost <= 1'b1;
        end
    end

    // Shadow divide ratios; zero is promoted to 1, out-of-range selects are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) shadow[i] <= DIV_RST;
        end else if (bus.div_wr && (int'(bus.div_sel) < N_CH)) begin
            shadow[bus.div_sel] <= (bus.div_val == '0) ? CNT_W'(1) : bus.div_val;
        end
    end

    // Enable decode from registered count and active ratio only.
    always_comb begin
        ce_c = '0;
        for (int i = 0; i < N_CH; i++) begin
            ce_c[i] = !rst_out_c[i] && (cnt[i] == act[i] - CNT_W'(1));
        end
    end

    // Per-channel divider: the shadow ratio is only picked up at a wrap or while held in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
                act[i] <= DIV_RST;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (rst_out_c[i] || !lock_s || ce_c[i]) begin
                    cnt[i] <= '0;
                    act[i] <= shadow[i];
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign bus.ce      = ce_c;
    assign bus.rst_out = rst_out_c;
    assign bus.ready   = ready_c;
    assign bus.lost    = lost;
endmodule

// File: tb/tb_clk_en_gen.sv
// Purpose: directed bench for clk_en_gen; stimulus queues timed expectations, a monitor compares them on negedges.
// Latency: expectations are indexed by rising-edge count, sampled in the following low phase.
// Backpressure: none; the monitor drains every expectation whose cycle has arrived.
`timescale 1ns/1ps
module tb_clk_en_gen;
    localparam int N_CH  = 4;
    localparam int CNT_W = 8;

    localparam logic [2:0] K_RST  = 3'd0;
    localparam logic [2:0] K_CE   = 3'd1;
    localparam logic [2:0] K_RDY  = 3'd2;
    localparam logic [2:0] K_LOST = 3'd3;
    localparam logic [2:0] K_CEB  = 3'd4;

    typedef struct packed {
        int          cyc;
        logic [2:0]  kind;
        logic [1:0]  idx;
        logic [3:0]  val;
        logic [95:0] nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   ecnt  = 0;
    int   nvec  = 0;
    int   nfail = 0;
    exp_t sbq[$];

    clk_en_gen_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

    clk_en_gen #(
        .N_CH(N_CH), .CNT_W(CNT_W), .LOCK_FILT(16), .RST_STAGGER(8), .DIV_INIT(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // Rising-edge counter: cycle c is the interval after edge c.
    always @(posedge clk) ecnt <= ecnt + 1;

    // Insert an expectation keeping the scoreboard ordered by cycle.
    task automatic exp_at(input int cyc, input logic [2:0] kind, input int idx,
                          input logic [3:0] val, input logic [95:0] nm);
        exp_t e;
        int   pos;
        e.cyc  = cyc;
        e.kind = kind;
        e.idx  = idx[1:0];
        e.val  = val;
        e.nm   = nm;
        pos = sbq.size();
        for (int i = 0; i < sbq.size(); i++) begin
            if (sbq[i].cyc > cyc) begin
                pos = i;
                break;
            end
        end
        sbq.insert(pos, e);
    endtask

    task automatic wait_to(input int c);
        while (ecnt < c) @(negedge clk);
    endtask

    // Monitor: compare every expectation that falls due this cycle.
    always @(negedge clk) begin
        exp_t       e;
        logic [3:0] got;
        while (sbq.size() > 0 && sbq[0].cyc <= ecnt) begin
            e = sbq.pop_front();
            case (e.kind)
                K_RST:   got = bus.rst_out;
                K_CE:    got = bus.ce;
                K_RDY:   got = {3'b000, bus.ready};
                K_LOST:  got = {3'b000, bus.lost};
                default: got = {3'b000, bus.ce[e.idx]};
            endcase
            nvec++;
            if (e.cyc != ecnt || got !== e.val) begin
                nfail++;
                $display("FAIL %0s cyc=%0d now=%0d got=%h want=%h", e.nm, e.cyc, ecnt, got, e.val);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, now=%0d want_end=done", ecnt);
        $fatal(1, "watchdog");
    end

    initial begin
        int b, w, x, l, c;
        rst         = 1'b1;
        bus.lock    = 1'b0;
        bus.div_wr  = 1'b0;
        bus.div_sel = '0;
        bus.div_val = '0;
        @(negedge clk);

        // Reset state, three reset edges.
        b = ecnt;
        exp_at(b + 1, K_RST,  0, 4'hF, "rst_rstout");
        exp_at(b + 1, K_CE,   0, 4'h0, "rst_ce");
        exp_at(b + 1, K_RDY,  0, 4'h0, "rst_ready");
        exp_at(b + 1, K_LOST, 0, 4'h0, "rst_lost");
        wait_to(b + 2);

        // Staggered release with steady lock.
        b = ecnt;
        rst      = 1'b0;
        bus.lock = 1'b1;
        exp_at(b + 18, K_RST,  0, 4'hF, "t1_r18");
        exp_at(b + 18, K_CE,   0, 4'h0, "t1_ce_pre");
        exp_at(b + 19, K_RST,  0, 4'hE, "t1_r19");
        exp_at(b + 19, K_CE,   0, 4'h1, "t1_ce19");
        exp_at(b + 26, K_RST,  0, 4'hE, "t1_r26");
        exp_at(b + 27, K_RST,  0, 4'hC, "t1_r27");
        exp_at(b + 34, K_RST,  0, 4'hC, "t1_r34");
        exp_at(b + 35, K_RST,  0, 4'h8, "t1_r35");
        exp_at(b + 42, K_RST,  0, 4'h8, "t1_r42");
        exp_at(b + 42, K_RDY,  0, 4'h0, "t1_rdy42");
        exp_at(b + 43, K_RST,  0, 4'h0, "t1_r43");
        exp_at(b + 43, K_RDY,  0, 4'h1, "t1_rdy43");
        exp_at(b + 43, K_LOST, 0, 4'h0, "t1_lost");
        exp_at(b + 43, K_CE,   0, 4'hF, "t1_ce43");
        wait_to(b + 50);
        nvec++;
        if (bus.rst_out !== 4'h0 || bus.ready !== 1'b1) begin
            nfail++;
            $display("FAIL t1_steady now=%0d got=%h/%b want=0/1", ecnt, bus.rst_out, bus.ready);
        end

        // ch2 -> 5 and ch3 -> 0 (treated as 1) on consecutive edges.
        w = ecnt;
        exp_at(w + 1,  K_CEB, 2, 4'h1, "t3_c2_w1");
        exp_at(w + 2,  K_CEB, 2, 4'h0, "t3_c2_w2");
        exp_at(w + 5,  K_CEB, 2, 4'h0, "t3_c2_w5");
        exp_at(w + 6,  K_CEB, 2, 4'h1, "t3_c2_w6");
        exp_at(w + 7,  K_CEB, 2, 4'h0, "t3_c2_w7");
        exp_at(w + 10, K_CEB, 2, 4'h0, "t3_c2_w10");
        exp_at(w + 11, K_CEB, 2, 4'h1, "t3_c2_w11");
        exp_at(w + 16, K_CEB, 2, 4'h1, "t3_c2_w16");
        exp_at(w + 3,  K_CEB, 3, 4'h1, "t3_c3_w3");
        exp_at(w + 4,  K_CEB, 3, 4'h1, "t3_c3_w4");
        exp_at(w + 8,  K_CEB, 3, 4'h1, "t3_c3_w8");
        bus.div_wr  = 1'b1;
        bus.div_sel = 2'd2;
        bus.div_val = 8'd5;
        @(negedge clk);
        bus.div_sel = 2'd3;
        bus.div_val = 8'd0;
        @(negedge clk);
        bus.div_wr  = 1'b0;
        wait_to(w + 20);

        // ch1 -> 200, then 7 and 3 mid-period; last write wins at the next wrap.
        x = ecnt;
        exp_at(x + 1,   K_CEB, 1, 4'h1, "t4_x1");
        exp_at(x + 2,   K_CEB, 1, 4'h0, "t4_x2");
        exp_at(x + 150, K_CEB, 1, 4'h0, "t4_x150");
        exp_at(x + 200, K_CEB, 1, 4'h0, "t4_x200");
        exp_at(x + 201, K_CEB, 1, 4'h1, "t4_x201");
        exp_at(x + 202, K_CEB, 1, 4'h0, "t4_x202");
        exp_at(x + 203, K_CEB, 1, 4'h0, "t4_x203");
        exp_at(x + 204, K_CEB, 1, 4'h1, "t4_x204");
        exp_at(x + 205, K_CEB, 1, 4'h0, "t4_x205");
        exp_at(x + 207, K_CEB, 1, 4'h1, "t4_x207");
        bus.div_wr  = 1'b1;
        bus.div_sel = 2'd1;
        bus.div_val = 8'd200;
        @(negedge clk);
        bus.div_wr  = 1'b0;
        wait_to(x + 100);
        bus.div_wr  = 1'b1;
        bus.div_val = 8'd7;
        @(negedge clk);
        bus.div_val = 8'd3;
        @(negedge clk);
        bus.div_wr  = 1'b0;
        wait_to(x + 210);

        // Lock drop in RUN, then full re-release with lost held.
        l = ecnt;
        bus.lock = 1'b0;
        exp_at(l + 2, K_RST,  0, 4'h0, "t5_r2");
        exp_at(l + 2, K_RDY,  0, 4'h1, "t5_rdy2");
        exp_at(l + 2, K_LOST, 0, 4'h0, "t5_lost2");
        exp_at(l + 3, K_RST,  0, 4'hF, "t5_r3");
        exp_at(l + 3, K_RDY,  0, 4'h0, "t5_rdy3");
        exp_at(l + 3, K_CE,   0, 4'h0, "t5_ce3");
        exp_at(l + 3, K_LOST, 0, 4'h1, "t5_lost3");
        wait_to(l + 5);
        b = ecnt;
        bus.lock = 1'b1;
        exp_at(b + 18, K_RST,  0, 4'hF, "t5_rr18");
        exp_at(b + 19, K_RST,  0, 4'hE, "t5_rr19");
        exp_at(b + 19, K_CEB,  0, 4'h1, "t5_c0");
        exp_at(b + 28, K_CEB,  1, 4'h0, "t5_c1_28");
        exp_at(b + 29, K_CEB,  1, 4'h1, "t5_c1_29");
        exp_at(b + 32, K_CEB,  1, 4'h1, "t5_c1_32");
        exp_at(b + 38, K_CEB,  2, 4'h0, "t5_c2_38");
        exp_at(b + 39, K_CEB,  2, 4'h1, "t5_c2_39");
        exp_at(b + 43, K_RDY,  0, 4'h1, "t5_rdy43");
        exp_at(b + 43, K_LOST, 0, 4'h1, "t5_lost43");
        exp_at(b + 43, K_CEB,  3, 4'h1, "t5_c3");
        wait_to(b + 50);
        nvec++;
        if (bus.lost !== 1'b1 || bus.ready !== 1'b1) begin
            nfail++;
            $display("FAIL t5_steady now=%0d got=%b/%b want=1/1", ecnt, bus.lost, bus.ready);
        end

        // rst clears lost; then rst again in RELEASE restarts the e19 timing.
        l = ecnt;
        rst = 1'b1;
        exp_at(l + 1, K_LOST, 0, 4'h0, "t6_lost");
        exp_at(l + 1, K_RST,  0, 4'hF, "t6_r1");
        @(negedge clk);
        b = ecnt;
        rst = 1'b0;
        exp_at(b + 19, K_RST,  0, 4'hE, "t6_rel19");
        exp_at(b + 23, K_RST,  0, 4'hE, "t6_rel23");
        exp_at(b + 25, K_RST,  0, 4'hF, "t6_rst_r");
        exp_at(b + 25, K_CE,   0, 4'h0, "t6_rst_ce");
        exp_at(b + 25, K_RDY,  0, 4'h0, "t6_rst_rdy");
        exp_at(b + 25, K_LOST, 0, 4'h0, "t6_rst_lost");
        wait_to(b + 24);
        rst = 1'b1;
        @(negedge clk);
        c = ecnt;
        rst = 1'b0;
        exp_at(c + 18, K_RST, 0, 4'hF, "t6_rr18");
        exp_at(c + 19, K_RST, 0, 4'hE, "t6_rr19");
        exp_at(c + 27, K_RST, 0, 4'hC, "t6_rr27");
        exp_at(c + 43, K_RDY, 0, 4'h1, "t6_rdy43");
        wait_to(c + 50);

        // Lock pulse of 10 cycles must not release; release counts from the second rise.
        rst = 1'b1;
        bus.lock = 1'b0;
        @(negedge clk);
        b = ecnt;
        rst = 1'b0;
        bus.lock = 1'b1;
        exp_at(b + 20, K_RST, 0, 4'hF, "t2_pulse20");
        exp_at(b + 30, K_RST, 0, 4'hF, "t2_pulse30");
        wait_to(b + 10);
        bus.lock = 1'b0;
        wait_to(b + 15);
        c = ecnt;
        bus.lock = 1'b1;
        exp_at(c + 18, K_RST,  0, 4'hF, "t2_r18");
        exp_at(c + 19, K_RST,  0, 4'hE, "t2_r19");
        exp_at(c + 43, K_RDY,  0, 4'h1, "t2_rdy43");
        exp_at(c + 43, K_CE,   0, 4'hF, "t2_ce43");
        exp_at(c + 43, K_LOST, 0, 4'h0, "t2_lost");
        wait_to(c + 50);
        nvec++;
        if (bus.ready !== 1'b1 || bus.lost !== 1'b0) begin
            nfail++;
            $display("FAIL t2_steady now=%0d got=%b/%b want=1/0", ecnt, bus.ready, bus.lost);
        end

        // Anything still queued was never compared.
        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
        while (sbq.size() > 0) begin
            nvec++;
            nfail++;
            $display("FAIL %0s never_checked cyc=%0d now=%0d", sbq[0].nm, sbq[0].cyc, ecnt);
            void'(sbq.pop_front());
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
